// File: rtl/alu_add_seq.sv
// Multi-cycle chunked adder/subtractor: one CHUNK-bit slice per clock.
// Registered carry between slices; start/busy/done handshake.
//
// Ports:
//   clock, clear      : rising-edge clock, synchronous active-high reset
//   start             : accept a new operation (ignored while busy)
//   sub, cIn, A, B    : mode, carry-in, operands (latched at accept)
//   Sum, cOut, ovf    : result, carry out of MSB, signed overflow
//   busy, done        : operation in progress / result valid
module alu_add_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             sub,
  input  logic             cIn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic             cOut,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_param
    $error("alu_add_seq: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic             carry;
  logic             accept;
  logic             last;
  int               off;
  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK:0]   c_sum;
  logic             c_msb;

  assign accept = start && (state != S_RUN);
  assign last   = (cnt == CW'(NCH - 1));
  assign off    = int'(cnt) * CHUNK;

  always_comb begin
    a_c    = a_q[off +: CHUNK];
    b_c    = b_q[off +: CHUNK];
    c_sum  = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry};
    // Carry into the slice MSB: sum bit = a ^ b ^ carry_in.
    c_msb  = c_sum[CHUNK-1] ^ a_c[CHUNK-1] ^ b_c[CHUNK-1];
    acc_nx = acc;
    acc_nx[off +: CHUNK] = c_sum[CHUNK-1:0];
  end

  always_ff @(posedge clock) begin
    if (clear) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nx = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nx = S_RUN;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      cnt   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      Sum   <= '0;
      cOut  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_q   <= A;
      b_q   <= sub ? ~B : B;
      carry <= sub ? 1'b1 : cIn;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      acc   <= acc_nx;
      carry <= c_sum[CHUNK];
      cnt   <= last ? '0 : cnt + 1'b1;
      if (last) begin
        Sum  <= acc_nx;
        cOut <= c_sum[CHUNK];
        ovf  <= c_msb ^ c_sum[CHUNK];
      end
    end
  end

endmodule

// File: doc/alu_add_seq.md
Name: alu_add_seq

Overview:
- Parametrised multi-cycle adder/subtractor for the ALU datapath. It is the successor to the single-cycle 32-bit ripple adder.
- Splits a WIDTH-bit add or subtract into WIDTH/CHUNK chunk-additions, one chunk per clock. The carry is registered between chunks, which shortens the critical path.
- Adds a start/busy/done handshake, a subtract mode, external carry-in, and carry-out and signed-overflow flags. The ALU control FSM starts it and waits on done.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits added per cycle. WIDTH % CHUNK == 0 is required; elaboration fails otherwise. CHUNK == WIDTH gives single-chunk operation.

Ports:
- clock  input  1  system clock, rising edge.
- clear  input  1  reset, synchronous, active-high.
- start  input  1  request a new operation; sampled on the rising edge.
- sub  input  1  0 = A+B+cIn; 1 = A-B (A + ~B + 1, cIn ignored). Latched at accept.
- cIn  input  1  carry-in for add mode. Latched at accept.
- A  input  WIDTH  operand A. Latched at accept.
- B  input  WIDTH  operand B. Latched at accept.
- Sum  output  WIDTH  result. Valid while done=1.
- cOut  output  1  carry out of the MSB. In sub mode, 1 means no borrow. Valid while done=1.
- ovf  output  1  signed overflow = (carry into MSB) XOR (carry out of MSB). Valid while done=1.
- busy  output  1  operation in progress.
- done  output  1  result valid. Held until the next accepted start or clear.

Behaviour:
- NCH = WIDTH/CHUNK. Internal state:
  - chunk counter, ceil(log2(NCH)) bits, minimum 1;
  - latched operands, with B already inverted when sub=1;
  - running carry register;
  - result accumulator.
- Reset: clear=1 at a rising edge forces the following:
  - state = IDLE;
  - Sum = 0, cOut = 0, ovf = 0, busy = 0, done = 0;
  - counter = 0, carry = 0.
  - clear has priority over start on the same edge.
  - clear mid-RUN aborts the operation; no partial result is ever presented.
- States: IDLE, RUN, DONE.
  - IDLE: busy=0, done=0. start=1 → latch A, B (inverted if sub), and initial carry (1 if sub, else cIn). Set counter=0, go to RUN.
  - RUN: busy=1, done=0. Each edge adds chunk[counter] of the latched A and B plus the carry register. The chunk sum is written into the accumulator at that bit offset; the carry register is updated and counter increments.
  - On the edge processing chunk NCH-1:
    - Sum is loaded with the full result, and cOut with the final carry;
    - ovf is loaded with carry-in-to-MSB XOR carry-out-of-MSB, captured from that last chunk;
    - go to DONE.
  - start is ignored in RUN; operand inputs are don't-care after accept.
  - DONE: busy=0, done=1, and Sum, cOut and ovf hold. start=1 → accept a new operation exactly as in IDLE. On that edge done falls and busy rises; Sum, cOut and ovf keep their old values until the new result loads.
- Latency: start accepted on edge E0. Processing edges are E1 through ENCH, and done=1 after edge ENCH. Defaults give 4 cycles; CHUNK=WIDTH gives 1 cycle.
- Throughput with back-to-back starts: one result per NCH+1 cycles. This is one DONE cycle minimum when start is held high continuously.
- Sum, cOut and ovf change only on the final chunk edge or on clear. They never show intermediate values.
- Wrap-around: arithmetic is modulo 2^WIDTH. Overflow is reported only through cOut and ovf.
- ovf needs the carry into bit WIDTH-1. It is taken inside the last chunk, so the last chunk must expose its bit CHUNK-2 carry. When CHUNK=1, that carry is the carry register before the last edge.

Test Plan:
- Add with full carry, defaults: A=0xFFFFFFFF, B=0x00000001, sub=0, cIn=0, start one cycle → busy=1 for 4 cycles. done=1 after the 4th processing edge with Sum=0x00000000, cOut=1, ovf=0.
- Signed overflow: A=0x7FFFFFFF, B=0x1, add → Sum=0x80000000, cOut=0, ovf=1. Then A=0x80000000, B=0x1, sub=1 → Sum=0x7FFFFFFF, cOut=1, ovf=1.
- Subtract with borrow: A=5, B=7, sub=1, cIn=1 (ignored) → Sum=0xFFFFFFFE, cOut=0, ovf=0. Then A=3, B=0, cIn=1, add → Sum=4, cOut=0, ovf=0.
- Handshake:
  - start pulsed again during RUN with different operands → ignored, and the original result is delivered.
  - start held high continuously → done high exactly one cycle between operations, with a new result every 5 cycles.
  - Sum stays stable between results.
- Reset mid-operation: clear=1 on the 2nd RUN edge → next cycle all outputs 0, state IDLE. A following start produces a correct fresh result. start and clear asserted together → stays IDLE.
- Parameter sweep: (WIDTH,CHUNK) = (32,32), (32,1), (16,4), (64,16). Random operands against a behavioural model of the result, cOut and ovf. Check latency equals NCH cycles in each configuration.
